// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Sequences MEM-stage loads and stores over a valid/ready request channel and
// a valid-only response channel to a variable-latency data memory. The
// pipeline is frozen through `stall` until the access finishes. Load data and
// the completion pulse reach writeback together in a single DONE cycle.
//
// Optional feature: define DMEM_TIMEOUT_EN to build the REQ+WAIT watchdog.
// When the watchdog is enabled, an access still open after TIMEOUT_CYCLES
// cycles is aborted. The abort completes with err = 1 and rdata_m = 0.
// When it is not enabled, err is tied low and the controller waits
// indefinitely.
module dmem_access_ctrl #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid_m,
    input  logic             mem_write_m,
    input  logic [WIDTH-1:0] addr_m,
    input  logic [WIDTH-1:0] wdata_m,
    output logic             stall,
    output logic [WIDTH-1:0] rdata_m,
    output logic             done_m,
    output logic             req_valid,
    output logic             req_write,
    output logic [WIDTH-1:0] req_addr,
    output logic [WIDTH-1:0] req_wdata,
    input  logic             req_ready,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic               req_valid_q;
    logic               req_write_q;
    logic [WIDTH-1:0]   req_addr_q;
    logic [WIDTH-1:0]   req_wdata_q;
    logic [WIDTH-1:0]   rdata_q;
    logic               done_q;

    logic               start;
    logic               in_flight;
    logic               complete;
    logic               expire;

    // The counter must be able to reach TIMEOUT_CYCLES-1. If a configuration
    // cannot do that, it shows up in the elaborated hierarchy as this marker
    // block.
    if ((CNT_W < 1) || ((CNT_W < 31) && ((1 << CNT_W) <= TIMEOUT_CYCLES))) begin : g_cnt_w_too_small
    end

    // A new access is taken only from IDLE. In DONE the completing
    // instruction is still on mem_valid_m and must not be issued again.
    assign start     = (state_q == IDLE) && mem_valid_m;
    assign in_flight = (state_q == REQ) || (state_q == WAIT);

    // Normal completion has two forms. A store completes when its request is
    // accepted, because writes are posted. A load completes when its
    // response arrives while in WAIT. A response seen in any other state is
    // ignored.
    assign complete = ((state_q == REQ) && req_ready && req_write_q) ||
                      ((state_q == WAIT) && resp_valid);

`ifdef DMEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             err_q;

    assign cnt_d  = cnt_q + CNT_W'(1);
    assign expire = in_flight && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count cycles spent in REQ+WAIT. The count restarts when a new access is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (in_flight) begin
            cnt_q <= cnt_d;
        end
    end

    // Flag an abort for its DONE cycle. A completion in the same cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= expire && !complete;
        end
    end

    assign err = err_q;
`else
    assign expire = 1'b0;
    assign err    = 1'b0;
`endif

    // Access sequencer. Every output is registered here, except stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_valid_m) begin
                        req_write_q <= mem_write_m;
                        req_addr_q  <= addr_m;
                        req_wdata_q <= wdata_m;
                        req_valid_q <= 1'b1;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    // req_* are held here until the memory takes the request.
                    if (complete) begin
                        req_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end else if (expire) begin
                        req_valid_q <= 1'b0;
                        rdata_q     <= '0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end else if (req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (complete) begin
                        rdata_q <= resp_data;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (expire) begin
                        rdata_q <= '0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The stall is combinational. The pipeline then freezes in the same
    // cycle that an access shows up in IDLE.
    assign stall     = start || in_flight;

    assign req_valid = req_valid_q;
    assign req_write = req_write_q;
    assign req_addr  = req_addr_q;
    assign req_wdata = req_wdata_q;
    assign rdata_m   = rdata_q;
    assign done_m    = done_q;

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences every data-memory access issued by the MEM stage of the 5-stage pipeline over a valid/ready request and response interface to a variable-latency data memory.
- Holds the EXE-to-MEM and upstream pipeline registers via `stall` until the access completes.
- Presents load data to writeback on the completion cycle.
- Sits beside the EXE-to-MEM pipeline register, which drives its `*_m` inputs.

Parameters:
- WIDTH, 32, data and address width.
- TIMEOUT_CYCLES, 255, maximum cycles spent in REQ+WAIT before abort (used only with the optional feature).
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_valid_m  in  1  MEM-stage instruction is a load or store.
- mem_write_m  in  1  1 = store, 0 = load.
- addr_m  in  WIDTH  byte address (ALUResultM).
- wdata_m  in  WIDTH  store data (WriteDataM).
- stall  out  1  freeze pipeline registers.
- rdata_m  out  WIDTH  load result, valid when done_m = 1.
- done_m  out  1  access complete this cycle.
- req_valid  out  1  request to memory.
- req_write  out  1  request type.
- req_addr  out  WIDTH  request address.
- req_wdata  out  WIDTH  request store data.
- req_ready  in  1  memory accepts the request.
- resp_valid  in  1  load data returned.
- resp_data  in  WIDTH  load data.
- err  out  1  timeout abort pulse; tied 0 without the feature.

Behaviour:
- Reset (asynchronous, takes effect immediately): state = IDLE; req_valid, req_write, req_addr, req_wdata, rdata_m, done_m, err and the counter all = 0. A reset mid-access abandons the request; any later resp_valid is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If mem_valid_m = 1: capture mem_write_m, addr_m and wdata_m into the req_* registers, clear the counter, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - req_valid = 1. req_* are stable while req_valid = 1 and req_ready = 0.
  - When req_ready = 1: a store goes to DONE (posted write); a load goes to WAIT.
  - A resp_valid in REQ is ignored.
- WAIT:
  - When resp_valid = 1: rdata_m <= resp_data, go to DONE.
- DONE:
  - done_m = 1 for exactly one cycle, then return to IDLE.
  - mem_valid_m is not sampled in DONE, so the completing instruction is never re-issued.
- stall (combinational) = (IDLE and mem_valid_m) or REQ or WAIT. It is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Latency:
  - Zero-wait store: IDLE → REQ (ready = 1) → DONE, giving 2 stall cycles.
  - Load with response one cycle after acceptance: 3 stall cycles.
- Back-to-back accesses: the instruction that enters MEM after DONE is seen in IDLE the following cycle. There is one bubble-free idle cycle between accesses.
- rdata_m holds its last value until the next load completes. A store does not modify rdata_m.
- resp_valid in IDLE or DONE is ignored.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- With the macro:
  - The counter increments every cycle in REQ or WAIT.
  - When counter == TIMEOUT_CYCLES-1 and the access has not completed: go to DONE, drive err = 1 for that DONE cycle, set rdata_m = 0, and drop req_valid.
  - Completion in the same cycle as the timeout takes priority: normal DONE, err = 0.
- Without the macro: no counter is built, err is tied to 0, and the controller waits indefinitely.

Test Plan:
- Reset mid-WAIT: assert rst while waiting on a load → req_valid, stall and done_m are 0 immediately. A later resp_valid = 1 with 0xDEAD is ignored, and rdata_m stays 0.
- Zero-wait store: addr_m = 0x100, wdata_m = 0xCAFEF00D, req_ready tied 1 → req_valid is high for 1 cycle with those values and req_write = 1. stall is high for 2 cycles, done_m pulses once, and rdata_m is unchanged.
- Load with backpressure: req_ready = 0 for 3 cycles, then 1; resp_valid arrives 2 cycles later with 0x12345678 → req_* stay stable throughout. stall is high for 7 cycles, then done_m = 1 with rdata_m = 0x12345678.
- Back-to-back load then store with mem_valid_m held: each access is issued exactly once. Exactly two done_m pulses occur and there is no duplicate request.
- Spurious response: resp_valid = 1 while IDLE → no state change and rdata_m unchanged.
- With DMEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, load with resp_valid never asserted → exactly 4 cycles are spent in REQ+WAIT, then DONE with err = 1 and rdata_m = 0. A second case with resp_valid on the 4th cycle ends with err = 0 and the returned data in rdata_m.
